// File: rtl/rr4_arb_pkg.sv
// rr4_arb_pkg: shared states, constants and round-robin pick for the decode arbiter
package rr4_arb_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, GAP = 2'd2} state_t;
    localparam int NUM_REQ = 4;
    localparam logic [NUM_REQ-1:0] IDLE_GNT_N = 4'b1111;
    function automatic logic [1:0] rr_pick(input logic [NUM_REQ-1:0] req, input logic [1:0] ptr);
        logic [1:0] c;
        rr_pick = ptr;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            c = ptr + 2'(k);
            if (req[c]) rr_pick = c;
        end
    endfunction
endpackage

// File: rtl/rr4_decode_arbiter_if.sv
// rr4_decode_arbiter_if: request/enable inputs and decoded grant outputs of the arbiter
interface rr4_decode_arbiter_if;
    import rr4_arb_pkg::*;
    logic en;
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] gnt_n;
    logic [1:0] gnt_idx;
    logic gnt_valid;
    logic timeout;
    modport master (output en, req, input gnt_n, gnt_idx, gnt_valid, timeout);
    modport slave (input en, req, output gnt_n, gnt_idx, gnt_valid, timeout);
endinterface

// File: rtl/dec2to4_n.sv
// dec2to4_n: active-low 2-to-4 decoder with active-low enable
module dec2to4_n
    import rr4_arb_pkg::*;
(
    input  logic [1:0]         sel,
    input  logic               en_n,
    output logic [NUM_REQ-1:0] y_n
);
    always_comb y_n = en_n ? IDLE_GNT_N : ~(4'b0001 << sel);
endmodule

// File: rtl/rr4_decode_arbiter.sv
// rr4_decode_arbiter: round-robin owner of a shared active-low decoded select bus
module rr4_decode_arbiter
    import rr4_arb_pkg::*;
#(
    parameter int MAX_HOLD = 15,
    parameter int CNT_W = 8
) (
    input logic clk,
    input logic rst_n,
    rr4_decode_arbiter_if.slave bus
);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);
    state_t state_q, state_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [1:0] rr_ptr_q, rr_ptr_d, gnt_idx_q, gnt_idx_d;
    logic [NUM_REQ-1:0] gnt_n_q, gnt_n_d;
    logic timeout_q, timeout_d;
    always_comb begin
        state_d = state_q;
        hold_cnt_d = hold_cnt_q;
        rr_ptr_d = rr_ptr_q;
        gnt_idx_d = gnt_idx_q;
        timeout_d = 1'b0;
        if (state_q == GRANT) begin
            if (!bus.req[gnt_idx_q] || hold_cnt_q == HOLD_LAST) begin
                state_d = GAP;
                rr_ptr_d = gnt_idx_q + 2'd1;
                timeout_d = bus.req[gnt_idx_q];
            end else hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end else begin
            state_d = (|bus.req) ? GRANT : IDLE;
            gnt_idx_d = (|bus.req) ? rr_pick(bus.req, rr_ptr_q) : gnt_idx_q;
            hold_cnt_d = '0;
        end
        if (!bus.en) begin
            state_d = IDLE;
            timeout_d = 1'b0;
            rr_ptr_d = rr_ptr_q;
            gnt_idx_d = gnt_idx_q;
        end
    end
    dec2to4_n u_dec (.sel(gnt_idx_d), .en_n(state_d != GRANT), .y_n(gnt_n_d));
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            hold_cnt_q <= '0;
            rr_ptr_q <= 2'd0;
            gnt_idx_q <= 2'd0;
            gnt_n_q <= IDLE_GNT_N;
            timeout_q <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_cnt_q <= hold_cnt_d;
            rr_ptr_q <= rr_ptr_d;
            gnt_idx_q <= gnt_idx_d;
            gnt_n_q <= gnt_n_d;
            timeout_q <= timeout_d;
        end
    end
    assign bus.gnt_n = gnt_n_q;
    assign bus.gnt_idx = gnt_idx_q;
    assign bus.gnt_valid = (state_q == GRANT);
    assign bus.timeout = timeout_q;
endmodule

// File: tb/tb_rr4_decode_arbiter.sv
// tb_rr4_decode_arbiter: directed vector table plus timeout, MAX_HOLD=1 and break-before-make checks
module tb_rr4_decode_arbiter;
    typedef struct {
        logic       rst_n;
        logic       en;
        logic [3:0] req;
        logic [3:0] gnt_n;
        logic       valid;
        logic [1:0] idx;
        logic       to;
    } vec_t;
    logic clk = 1'b0;
    logic rst_n, rst1_n, en;
    logic [3:0] req;
    logic mon_on = 1'b0;
    logic [3:0] prev_a = 4'b1111, prev_b = 4'b1111;
    int checks = 0, passes = 0;
    vec_t vq[$];
    rr4_decode_arbiter_if ifa ();
    rr4_decode_arbiter_if ifb ();
    assign ifa.en = en;
    assign ifa.req = req;
    assign ifb.en = en;
    assign ifb.req = req;
    rr4_decode_arbiter u0 (.clk(clk), .rst_n(rst_n), .bus(ifa));
    rr4_decode_arbiter #(.MAX_HOLD(1)) u1 (.clk(clk), .rst_n(rst1_n), .bus(ifb));
    always #5 clk = ~clk;
    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    function automatic vec_t mk(logic r, logic e, logic [3:0] q, logic [3:0] g, logic v, logic [1:0] i, logic t);
        vec_t x;
        x.rst_n = r; x.en = e; x.req = q; x.gnt_n = g; x.valid = v; x.idx = i; x.to = t;
        return x;
    endfunction
    always @(negedge clk) begin
        if (mon_on) begin
            chk("one_low_a", 8'($countones(~ifa.gnt_n) > 1), 8'd0);
            chk("bbm_a", 8'(prev_a != 4'b1111 && ifa.gnt_n != 4'b1111 && prev_a != ifa.gnt_n), 8'd0);
            chk("bbm_b", 8'(prev_b != 4'b1111 && ifb.gnt_n != 4'b1111 && prev_b != ifb.gnt_n), 8'd0);
            prev_a = ifa.gnt_n;
            prev_b = ifb.gnt_n;
        end
    end
    initial begin
        rst_n = 1'b0; rst1_n = 1'b0; en = 1'b1; req = 4'b1111;
        vq.push_back(mk(0, 1, 4'b1111, 4'b1111, 0, 0, 0));
        vq.push_back(mk(0, 1, 4'b1111, 4'b1111, 0, 0, 0));
        vq.push_back(mk(1, 1, 4'b0100, 4'b1011, 1, 2, 0));
        vq.push_back(mk(1, 1, 4'b0100, 4'b1011, 1, 2, 0));
        vq.push_back(mk(1, 1, 4'b0100, 4'b1011, 1, 2, 0));
        vq.push_back(mk(1, 1, 4'b0100, 4'b1011, 1, 2, 0));
        vq.push_back(mk(1, 1, 4'b0000, 4'b1111, 0, 0, 0));
        vq.push_back(mk(1, 1, 4'b0000, 4'b1111, 0, 0, 0));
        vq.push_back(mk(1, 1, 4'b1111, 4'b0111, 1, 3, 0));
        vq.push_back(mk(1, 1, 4'b1111, 4'b0111, 1, 3, 0));
        vq.push_back(mk(1, 1, 4'b0111, 4'b1111, 0, 0, 0));
        vq.push_back(mk(1, 1, 4'b1111, 4'b1110, 1, 0, 0));
        vq.push_back(mk(1, 1, 4'b1111, 4'b1110, 1, 0, 0));
        vq.push_back(mk(1, 1, 4'b1110, 4'b1111, 0, 0, 0));
        vq.push_back(mk(1, 1, 4'b1111, 4'b1101, 1, 1, 0));
        vq.push_back(mk(1, 1, 4'b1111, 4'b1101, 1, 1, 0));
        vq.push_back(mk(1, 1, 4'b1101, 4'b1111, 0, 0, 0));
        vq.push_back(mk(1, 1, 4'b1111, 4'b1011, 1, 2, 0));
        vq.push_back(mk(1, 1, 4'b1111, 4'b1011, 1, 2, 0));
        vq.push_back(mk(1, 1, 4'b1011, 4'b1111, 0, 0, 0));
        vq.push_back(mk(1, 1, 4'b1111, 4'b0111, 1, 3, 0));
        vq.push_back(mk(1, 1, 4'b0111, 4'b1111, 0, 0, 0));
        vq.push_back(mk(1, 1, 4'b0000, 4'b1111, 0, 0, 0));
        vq.push_back(mk(1, 1, 4'b0100, 4'b1011, 1, 2, 0));
        vq.push_back(mk(1, 1, 4'b0000, 4'b1111, 0, 0, 0));
        vq.push_back(mk(1, 1, 4'b1000, 4'b0111, 1, 3, 0));
        vq.push_back(mk(1, 0, 4'b1000, 4'b1111, 0, 0, 0));
        vq.push_back(mk(1, 1, 4'b1001, 4'b0111, 1, 3, 0));
        vq.push_back(mk(1, 1, 4'b0000, 4'b1111, 0, 0, 0));
        vq.push_back(mk(1, 0, 4'b1111, 4'b1111, 0, 0, 0));
        vq.push_back(mk(1, 0, 4'b1111, 4'b1111, 0, 0, 0));
        vq.push_back(mk(1, 1, 4'b0010, 4'b1101, 1, 1, 0));
        vq.push_back(mk(0, 1, 4'b0010, 4'b1111, 0, 0, 0));
        vq.push_back(mk(1, 1, 4'b1111, 4'b1110, 1, 0, 0));
        vq.push_back(mk(1, 1, 4'b0000, 4'b1111, 0, 0, 0));
        vq.push_back(mk(1, 1, 4'b0000, 4'b1111, 0, 0, 0));
        foreach (vq[i]) begin
            rst_n = vq[i].rst_n; en = vq[i].en; req = vq[i].req;
            step();
            mon_on = 1'b1;
            chk($sformatf("v%0d_gnt_n", i), 8'(ifa.gnt_n), 8'(vq[i].gnt_n));
            chk($sformatf("v%0d_valid", i), 8'(ifa.gnt_valid), 8'(vq[i].valid));
            chk($sformatf("v%0d_timeout", i), 8'(ifa.timeout), 8'(vq[i].to));
            if (vq[i].valid) chk($sformatf("v%0d_idx", i), 8'(ifa.gnt_idx), 8'(vq[i].idx));
        end
        req = 4'b0001;
        for (int i = 0; i < 15; i++) begin
            step();
            chk($sformatf("hold%0d_gnt_n", i), 8'(ifa.gnt_n), 8'h0e);
            chk($sformatf("hold%0d_timeout", i), 8'(ifa.timeout), 8'd0);
        end
        step();
        chk("to_gap_gnt_n", 8'(ifa.gnt_n), 8'h0f);
        chk("to_pulse", 8'(ifa.timeout), 8'd1);
        step();
        chk("regrant_gnt_n", 8'(ifa.gnt_n), 8'h0e);
        chk("regrant_timeout", 8'(ifa.timeout), 8'd0);
        chk("regrant_idx", 8'(ifa.gnt_idx), 8'd0);
        req = 4'b0000;
        step();
        chk("to_release_gnt_n", 8'(ifa.gnt_n), 8'h0f);
        chk("to_release_timeout", 8'(ifa.timeout), 8'd0);
        step();
        rst1_n = 1'b1; req = 4'b0100;
        step();
        chk("mh1_grant", 8'(ifb.gnt_n), 8'h0b);
        chk("mh1_grant_to", 8'(ifb.timeout), 8'd0);
        step();
        chk("mh1_gap", 8'(ifb.gnt_n), 8'h0f);
        chk("mh1_gap_to", 8'(ifb.timeout), 8'd1);
        step();
        chk("mh1_regrant", 8'(ifb.gnt_n), 8'h0b);
        chk("mh1_regrant_to", 8'(ifb.timeout), 8'd0);
        req = 4'b0000;
        step();
        chk("mh1_release", 8'(ifb.gnt_n), 8'h0f);
        chk("mh1_release_to", 8'(ifb.timeout), 8'd0);
        step();
        chk("mh1_idle_valid", 8'(ifb.gnt_valid), 8'd0);
        mon_on = 1'b0;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
